// File: rtl/tlb.sv
// Fully associative software-managed MIPS TLB: one write port (TLBWI), one read
// port (TLBR) and two independent combinational search ports.
module tlb #(
    parameter int TLBNUM = 16
) (
    input  logic        clk,
    input  logic        reset,

    input  logic [18:0] s0_vpn2,
    input  logic        s0_odd_page,
    input  logic [7:0]  s0_asid,
    output logic        s0_found,
    output logic [3:0]  s0_index,
    output logic [19:0] s0_pfn,
    output logic [2:0]  s0_c,
    output logic        s0_d,
    output logic        s0_v,

    input  logic [18:0] s1_vpn2,
    input  logic        s1_odd_page,
    input  logic [7:0]  s1_asid,
    output logic        s1_found,
    output logic [3:0]  s1_index,
    output logic [19:0] s1_pfn,
    output logic [2:0]  s1_c,
    output logic        s1_d,
    output logic        s1_v,

    input  logic        we,
    input  logic [3:0]  w_index,
    input  logic [18:0] w_vpn2,
    input  logic [7:0]  w_asid,
    input  logic        w_g,
    input  logic [19:0] w_pfn0,
    input  logic [2:0]  w_c0,
    input  logic        w_d0,
    input  logic        w_v0,
    input  logic [19:0] w_pfn1,
    input  logic [2:0]  w_c1,
    input  logic        w_d1,
    input  logic        w_v1,

    input  logic [3:0]  r_index,
    output logic [18:0] r_vpn2,
    output logic [7:0]  r_asid,
    output logic        r_g,
    output logic [19:0] r_pfn0,
    output logic [2:0]  r_c0,
    output logic        r_d0,
    output logic        r_v0,
    output logic [19:0] r_pfn1,
    output logic [2:0]  r_c1,
    output logic        r_d1,
    output logic        r_v1
);

    localparam int         IDXW = $clog2(TLBNUM);
    localparam logic [4:0] NUM  = 5'(TLBNUM);

    logic [TLBNUM-1:0] e_q;
    logic [18:0]       vpn2_q [TLBNUM];
    logic [7:0]        asid_q [TLBNUM];
    logic              g_q    [TLBNUM];
    logic [19:0]       pfn0_q [TLBNUM];
    logic [2:0]        c0_q   [TLBNUM];
    logic              d0_q   [TLBNUM];
    logic              v0_q   [TLBNUM];
    logic [19:0]       pfn1_q [TLBNUM];
    logic [2:0]        c1_q   [TLBNUM];
    logic              d1_q   [TLBNUM];
    logic              v1_q   [TLBNUM];

    logic [IDXW-1:0] w_idx;
    logic [IDXW-1:0] r_idx;
    logic            w_ok;
    logic            r_ok;

    assign w_idx = w_index[IDXW-1:0];
    assign r_idx = r_index[IDXW-1:0];
    assign w_ok  = {1'b0, w_index} < NUM;
    assign r_ok  = {1'b0, r_index} < NUM;

    always_ff @(posedge clk) begin
        if (reset) begin
            e_q <= '0;
            for (int i = 0; i < TLBNUM; i++) begin
                vpn2_q[i] <= '0;
                asid_q[i] <= '0;
                g_q[i]    <= 1'b0;
                pfn0_q[i] <= '0;
                c0_q[i]   <= '0;
                d0_q[i]   <= 1'b0;
                v0_q[i]   <= 1'b0;
                pfn1_q[i] <= '0;
                c1_q[i]   <= '0;
                d1_q[i]   <= 1'b0;
                v1_q[i]   <= 1'b0;
            end
        end else if (we && w_ok) begin
            e_q[w_idx]    <= 1'b1;
            vpn2_q[w_idx] <= w_vpn2;
            asid_q[w_idx] <= w_asid;
            g_q[w_idx]    <= w_g;
            pfn0_q[w_idx] <= w_pfn0;
            c0_q[w_idx]   <= w_c0;
            d0_q[w_idx]   <= w_d0;
            v0_q[w_idx]   <= w_v0;
            pfn1_q[w_idx] <= w_pfn1;
            c1_q[w_idx]   <= w_c1;
            d1_q[w_idx]   <= w_d1;
            v1_q[w_idx]   <= w_v1;
        end
    end

    // Result packs {found, index, pfn, c, d, v}; scanning upward and stopping at
    // the first hit makes the lowest matching index win.
    function automatic logic [29:0] lookup(input logic [18:0] vpn2,
                                           input logic        odd,
                                           input logic [7:0]  asid);
        logic [29:0] res;
        logic        hit;
        res = '0;
        hit = 1'b0;
        for (int i = 0; i < TLBNUM; i++) begin
            if (!hit && e_q[i] && vpn2_q[i] == vpn2 && (g_q[i] || asid_q[i] == asid)) begin
                hit = 1'b1;
                res = odd ? {1'b1, 4'(i), pfn1_q[i], c1_q[i], d1_q[i], v1_q[i]}
                          : {1'b1, 4'(i), pfn0_q[i], c0_q[i], d0_q[i], v0_q[i]};
            end
        end
        return res;
    endfunction

    logic [29:0] s0_res;
    logic [29:0] s1_res;

    always_comb begin
        s0_res = lookup(s0_vpn2, s0_odd_page, s0_asid);
        s1_res = lookup(s1_vpn2, s1_odd_page, s1_asid);
    end

    assign {s0_found, s0_index, s0_pfn, s0_c, s0_d, s0_v} = s0_res;
    assign {s1_found, s1_index, s1_pfn, s1_c, s1_d, s1_v} = s1_res;

    always_comb begin
        r_vpn2 = '0;
        r_asid = '0;
        r_g    = 1'b0;
        r_pfn0 = '0;
        r_c0   = '0;
        r_d0   = 1'b0;
        r_v0   = 1'b0;
        r_pfn1 = '0;
        r_c1   = '0;
        r_d1   = 1'b0;
        r_v1   = 1'b0;
        if (r_ok) begin
            r_vpn2 = vpn2_q[r_idx];
            r_asid = asid_q[r_idx];
            r_g    = g_q[r_idx];
            r_pfn0 = pfn0_q[r_idx];
            r_c0   = c0_q[r_idx];
            r_d0   = d0_q[r_idx];
            r_v0   = v0_q[r_idx];
            r_pfn1 = pfn1_q[r_idx];
            r_c1   = c1_q[r_idx];
            r_d1   = d1_q[r_idx];
            r_v1   = v1_q[r_idx];
        end
    end

endmodule

// File: tb/tb_tlb.sv
// Bench for tlb: directed checks from the TLB behaviour rules, then randomized
// traffic compared against an entry-list reference model.
module tb_tlb;

    typedef struct packed {
        logic [18:0] vpn2;
        logic [7:0]  asid;
        logic        g;
        logic [19:0] pfn0;
        logic [2:0]  c0;
        logic        d0;
        logic        v0;
        logic [19:0] pfn1;
        logic [2:0]  c1;
        logic        d1;
        logic        v1;
    } ent_t;

    logic        clk;
    logic        reset;
    logic [18:0] s0_vpn2, s1_vpn2;
    logic        s0_odd_page, s1_odd_page;
    logic [7:0]  s0_asid, s1_asid;
    logic        s0_found, s1_found;
    logic [3:0]  s0_index, s1_index;
    logic [19:0] s0_pfn, s1_pfn;
    logic [2:0]  s0_c, s1_c;
    logic        s0_d, s1_d, s0_v, s1_v;
    logic        we;
    logic [3:0]  w_index;
    ent_t        w_ent;
    logic [3:0]  r_index;
    logic [18:0] r_vpn2;
    logic [7:0]  r_asid;
    logic        r_g;
    logic [19:0] r_pfn0, r_pfn1;
    logic [2:0]  r_c0, r_c1;
    logic        r_d0, r_v0, r_d1, r_v1;

    logic [29:0] s0_obs, s1_obs;
    ent_t        r_obs;
    assign s0_obs = {s0_found, s0_index, s0_pfn, s0_c, s0_d, s0_v};
    assign s1_obs = {s1_found, s1_index, s1_pfn, s1_c, s1_d, s1_v};
    assign r_obs  = {r_vpn2, r_asid, r_g, r_pfn0, r_c0, r_d0, r_v0, r_pfn1, r_c1, r_d1, r_v1};

    tlb #(.TLBNUM(16)) dut (
        .clk(clk), .reset(reset),
        .s0_vpn2(s0_vpn2), .s0_odd_page(s0_odd_page), .s0_asid(s0_asid),
        .s0_found(s0_found), .s0_index(s0_index), .s0_pfn(s0_pfn),
        .s0_c(s0_c), .s0_d(s0_d), .s0_v(s0_v),
        .s1_vpn2(s1_vpn2), .s1_odd_page(s1_odd_page), .s1_asid(s1_asid),
        .s1_found(s1_found), .s1_index(s1_index), .s1_pfn(s1_pfn),
        .s1_c(s1_c), .s1_d(s1_d), .s1_v(s1_v),
        .we(we), .w_index(w_index),
        .w_vpn2(w_ent.vpn2), .w_asid(w_ent.asid), .w_g(w_ent.g),
        .w_pfn0(w_ent.pfn0), .w_c0(w_ent.c0), .w_d0(w_ent.d0), .w_v0(w_ent.v0),
        .w_pfn1(w_ent.pfn1), .w_c1(w_ent.c1), .w_d1(w_ent.d1), .w_v1(w_ent.v1),
        .r_index(r_index),
        .r_vpn2(r_vpn2), .r_asid(r_asid), .r_g(r_g),
        .r_pfn0(r_pfn0), .r_c0(r_c0), .r_d0(r_d0), .r_v0(r_v0),
        .r_pfn1(r_pfn1), .r_c1(r_c1), .r_d1(r_d1), .r_v1(r_v1)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: list of written entries
    ent_t m_ent [16];
    logic m_e   [16];

    int vectors     = 0;
    int miscompares = 0;
    logic [127:0] exp_q[$];
    logic [18:0]  vpn_pool [4];
    logic [7:0]   asid_pool [4];

    function automatic logic [29:0] ref_search(input logic [18:0] vpn2, input logic odd,
                                               input logic [7:0] asid);
        int hits[$];
        int lo[$];
        ent_t en;
        foreach (m_ent[i])
            if (m_e[i] && m_ent[i].vpn2 == vpn2 && (m_ent[i].g || m_ent[i].asid == asid))
                hits.push_back(i);
        if (hits.size() == 0) return '0;
        lo = hits.min();
        en = m_ent[lo[0]];
        if (odd) return {1'b1, 4'(lo[0]), en.pfn1, en.c1, en.d1, en.v1};
        return {1'b1, 4'(lo[0]), en.pfn0, en.c0, en.d0, en.v0};
    endfunction

    function automatic ent_t ref_read(input logic [3:0] idx);
        return m_e[idx] ? m_ent[idx] : '0;
    endfunction

    // Scoreboard compare
    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] expv);
        logic [127:0] e;
        exp_q.push_back(expv);
        e = exp_q.pop_front();
        vectors++;
        assert (obs === e) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, e);
        end
    endtask

    task automatic check_all(input string tag);
        #1;
        chk({tag, "_s0"}, 128'(s0_obs), 128'(ref_search(s0_vpn2, s0_odd_page, s0_asid)));
        chk({tag, "_s1"}, 128'(s1_obs), 128'(ref_search(s1_vpn2, s1_odd_page, s1_asid)));
        chk({tag, "_rd"}, 128'(r_obs), 128'(ref_read(r_index)));
    endtask

    // Driver: one clock edge, model follows the same edge
    task automatic step();
        @(posedge clk);
        if (reset) begin
            foreach (m_ent[i]) begin
                m_ent[i] = '0;
                m_e[i]   = 1'b0;
            end
        end else if (we) begin
            m_ent[w_index] = w_ent;
            m_e[w_index]   = 1'b1;
        end
        #1;
    endtask

    task automatic do_write(input logic [3:0] idx, input ent_t en);
        we      = 1'b1;
        w_index = idx;
        w_ent   = en;
        step();
        we      = 1'b0;
    endtask

    task automatic search0(input logic [18:0] vpn, input logic odd, input logic [7:0] asid);
        s0_vpn2 = vpn; s0_odd_page = odd; s0_asid = asid;
    endtask

    task automatic search1(input logic [18:0] vpn, input logic odd, input logic [7:0] asid);
        s1_vpn2 = vpn; s1_odd_page = odd; s1_asid = asid;
    endtask

    initial begin
        ent_t en;
        logic [95:0] rnd;

        vpn_pool[0] = 19'h00000; vpn_pool[1] = 19'h12345;
        vpn_pool[2] = 19'h7ffff; vpn_pool[3] = 19'h00777;
        asid_pool[0] = 8'h00; asid_pool[1] = 8'h05;
        asid_pool[2] = 8'hff; asid_pool[3] = 8'h02;
        foreach (m_ent[i]) begin
            m_ent[i] = '0;
            m_e[i]   = 1'b0;
        end

        reset = 1'b1; we = 1'b0; w_index = '0; w_ent = '0; r_index = '0;
        search0('0, 1'b0, '0);
        search1('0, 1'b0, '0);
        step();
        step();
        reset = 1'b0;

        // Cleared entries hold vpn2=0 but must not match
        search0(19'h00000, 1'b0, 8'h00);
        check_all("reset");
        chk("reset_s0_zero", 128'(s0_obs), 128'(0));
        chk("reset_rd_zero", 128'(r_obs), 128'(0));

        en = '0;
        en.vpn2 = 19'h12345; en.asid = 8'h05; en.pfn0 = 20'h00100; en.v0 = 1'b1;
        en.pfn1 = 20'h00200; en.c1 = 3'd3; en.d1 = 1'b1; en.v1 = 1'b1;
        do_write(4'd3, en);
        search1(19'h12345, 1'b1, 8'h05);
        check_all("e3_odd");
        chk("e3_odd_dir", 128'(s1_obs), 128'({1'b1, 4'd3, 20'h00200, 3'd3, 1'b1, 1'b1}));
        search1(19'h12345, 1'b0, 8'h05);
        check_all("e3_even");
        chk("e3_even_dir", 128'(s1_obs), 128'({1'b1, 4'd3, 20'h00100, 3'd0, 1'b0, 1'b1}));
        search1(19'h12345, 1'b1, 8'h06);
        check_all("e3_asid");
        chk("e3_asid_miss", 128'(s1_found), 128'(0));
        r_index = 4'd3;
        check_all("rd3");
        chk("rd3_dir", 128'(r_obs), 128'(en));
        r_index = 4'd5;
        check_all("rd5");
        chk("rd5_zero", 128'(r_obs), 128'(0));

        // Global entry; same-cycle search must still see the old contents
        en = '0;
        en.vpn2 = 19'h0abcd; en.asid = 8'h11; en.g = 1'b1; en.pfn0 = 20'h0beef; en.v0 = 1'b1;
        search0(19'h0abcd, 1'b0, 8'hff);
        we = 1'b1; w_index = 4'd7; w_ent = en;
        check_all("e7_wcyc");
        chk("e7_wcyc_miss", 128'(s0_found), 128'(0));
        step();
        we = 1'b0;
        check_all("e7_after");
        chk("e7_glob_hit", 128'({s0_found, s0_index}), 128'({1'b1, 4'd7}));

        // Duplicate tags: lowest index wins
        en = '0;
        en.vpn2 = 19'h00777; en.asid = 8'h02; en.pfn0 = 20'h00909;
        do_write(4'd9, en);
        en.pfn0 = 20'h00404;
        do_write(4'd4, en);
        search0(19'h00777, 1'b0, 8'h02);
        check_all("dup");
        chk("dup_idx4", 128'({s0_found, s0_index}), 128'({1'b1, 4'd4}));
        en.vpn2 = 19'h00778;
        do_write(4'd4, en);
        check_all("dup_ow");
        chk("dup_idx9", 128'({s0_found, s0_index}), 128'({1'b1, 4'd9}));

        // Random traffic over small tag pools so hits and duplicates are frequent
        for (int n = 0; n < 400; n++) begin
            rnd = {$urandom, $urandom, $urandom};
            en = rnd[77:0];
            en.vpn2 = vpn_pool[$urandom_range(0, 3)];
            en.asid = asid_pool[$urandom_range(0, 3)];
            en.g    = ($urandom_range(0, 3) == 0);
            w_ent   = en;
            w_index = 4'($urandom_range(0, 15));
            we      = ($urandom_range(0, 1) == 1);
            reset   = ($urandom_range(0, 59) == 0);
            r_index = 4'($urandom_range(0, 15));
            search0(vpn_pool[$urandom_range(0, 3)], 1'($urandom_range(0, 1)),
                    asid_pool[$urandom_range(0, 3)]);
            search1(vpn_pool[$urandom_range(0, 3)], 1'($urandom_range(0, 1)),
                    asid_pool[$urandom_range(0, 3)]);
            check_all("rand");
            step();
        end
        reset = 1'b0;
        we    = 1'b0;

        // Populate, then reset together with a write: everything is lost
        for (int i = 0; i < 4; i++) begin
            en = '0;
            en.vpn2 = vpn_pool[i]; en.g = 1'b1; en.v0 = 1'b1; en.v1 = 1'b1;
            en.pfn0 = 20'(i + 1);
            do_write(4'(i), en);
        end
        reset = 1'b1; we = 1'b1; w_index = 4'd5; w_ent = en;
        step();
        reset = 1'b0; we = 1'b0;
        for (int i = 0; i < 4; i++) begin
            search0(vpn_pool[i], 1'b0, 8'h00);
            search1(vpn_pool[i], 1'b1, 8'h00);
            check_all("post_rst");
            chk("post_rst_s0", 128'(s0_obs), 128'(0));
            chk("post_rst_s1", 128'(s1_obs), 128'(0));
        end
        for (int i = 0; i < 16; i++) begin
            r_index = 4'(i);
            #1;
            chk("post_rst_rd", 128'(r_obs), 128'(0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/tlb.md
# tlb

Fully associative, software-managed MIPS TLB that answers the TLB write, read and search requests issued by the pipeline. The write-back stage drives its write port on TLBWI and its read port on TLBR, from the CP0 EntryHi/EntryLo0/EntryLo1/Index values. Two search ports serve fetch address translation (s0) and data-side or TLBP lookup (s1). Storage is a register array updated at the clock edge; all lookups are combinational.

## Interface
- TLBNUM, 16, number of entries; power of two, 2..16; index fields are always 4 bits wide.
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- s0_vpn2  in  19  search-0 virtual page pair number (VA[31:13]).
- s0_odd_page  in  1  search-0 VA[12]: 0 selects the even half, 1 selects the odd half.
- s0_asid  in  8  search-0 address space ID.
- s0_found  out  1  search-0 hit.
- s0_index  out  4  index of the hitting entry.
- s0_pfn  out  20  physical frame number of the selected half.
- s0_c  out  3  cache attribute of the selected half.
- s0_d  out  1  dirty bit of the selected half.
- s0_v  out  1  valid bit of the selected half.
- s1_vpn2, s1_odd_page, s1_asid, s1_found, s1_index, s1_pfn, s1_c, s1_d, s1_v: same as s0, independent port.
- we  in  1  write enable (TLBWI).
- w_index  in  4  entry to write.
- w_vpn2 (19), w_asid (8), w_g (1)  in  entry tag fields.
- w_pfn0 (20), w_c0 (3), w_d0 (1), w_v0 (1)  in  even-page fields.
- w_pfn1 (20), w_c1 (3), w_d1 (1), w_v1 (1)  in  odd-page fields.
- r_index  in  4  entry to read (TLBR).
- r_vpn2 (19), r_asid (8), r_g (1), r_pfn0 (20), r_c0 (3), r_d0 (1), r_v0 (1), r_pfn1 (20), r_c1 (3), r_d1 (1), r_v1 (1)  out  fields of entry r_index.

## Operation
- Per entry: e (written-since-reset flag), vpn2, asid, g, pfn0/c0/d0/v0, pfn1/c1/d1/v1.
- Reset: every field of every entry, including e, is cleared to 0.
- Write: on a rising edge with we=1, reset=0 and w_index<TLBNUM:
  - all fields of entry w_index are loaded from the w_* inputs;
  - e is set to 1;
  - w_g is stored as presented; this block does not combine EntryLo G bits.
- we with w_index>=TLBNUM: the write is ignored and no state changes.
- Match rule for entry i: e[i] && vpn2[i]==s_vpn2 && (g[i] || asid[i]==s_asid).
- found is the OR of all entry matches.
- Several matching entries: the lowest matching index wins. This is deterministic and required, even though the architecture leaves it undefined.
- Hit outputs: index = winning index; pfn/c/d/v come from half 1 if odd_page=1, otherwise half 0.
- Miss outputs: found=0, index=0, pfn=0, c=0, d=0, v=0.
- A hit on an entry whose selected half has v=0 still reports found=1 with v=0. The consumer raises TLB-invalid, not TLB-refill.
- Read port: r_* returns the stored fields of entry r_index. If r_index>=TLBNUM, all r_* outputs are 0.
- Unwritten entries read back all zero.

## Timing
- Search and read are combinational, zero latency, with no handshake and no stall.
- Write latency: contents written at edge N are visible to search and read from cycle N+1.
- Searches and reads in the same cycle as a write see the old contents; there is no write-to-read bypass.
- Simultaneous s0, s1, read and write are all legal in the same cycle.
- Reset asserted mid-operation: the array is cleared at that edge and an asserted we is ignored. All search outputs are 0 and all r_* outputs are 0 from the next cycle.
- Reset values of outputs (cycle after reset), for any inputs:
  - s*_found=0, s*_index=0, s*_pfn=0, s*_c=0, s*_d=0, s*_v=0;
  - r_*=0.

## Test plan
- Reset, then search s0 with vpn2=0x00000, asid=0x00 -> s0_found=0 and every s0 output is 0. This checks the e flag: entries cleared to vpn2=0 must not match.
- Write entry 3: vpn2=0x12345, asid=0x05, g=0, pfn0=0x00100, v0=1, pfn1=0x00200, c1=3, d1=1, v1=1. Next cycle:
  - s1 search 0x12345 / asid 0x05 / odd=1 -> found=1, index=3, pfn=0x00200, c=3, d=1, v=1;
  - odd=0 -> pfn=0x00100, d=0, v=1;
  - asid 0x06 -> found=0.
- Write entry 7: vpn2=0x0ABCD, g=1, asid=0x11. s0 search 0x0ABCD with asid 0xFF -> found=1, index=7. In the write cycle itself the same search -> found=0.
- Write entries 9 and 4 with identical vpn2=0x00777, asid=0x02, then search -> index=4. Overwrite entry 4 with vpn2=0x00778 -> the next search for 0x00777 returns index=9.
- Read port:
  - r_index=3 after the entry-3 write -> r_vpn2=0x12345, r_asid=0x05, r_g=0, r_pfn1=0x00200, r_c1=3;
  - r_index=5 (unwritten) -> all r_* are 0.
- With entries populated, assert reset for 1 cycle together with we=1 -> every search misses and every r_* output is 0 afterwards. The write is lost.
